ram_refresh_sched: RTL and testbench

- Schedules DRAM refresh for the RAM controller. It produces the refresh request and refresh-urgent levels that the controller consumes.
- A free-running interval timer adds owed refreshes. An age timer escalates a stale request to urgent.
- Completion is detected from the controller's refresh-active indication.
- A mandatory one-cycle request gap after each completion lets the controller re-arm its "refresh done" latch.

---
 rtl/ram_ref_pkg.sv | 18 +
 rtl/ram_refresh_sched_timer.sv | 34 +++
 rtl/ram_refresh_sched.sv | 110 +++++++++++
 tb/tb_ram_refresh_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ref_pkg.sv
// Shared types and defaults for the DRAM refresh scheduler.
package ram_ref_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_GAP  = 2'd2
  } ref_state_e;

  localparam int unsigned REF_PERIOD_DEF = 390;
  localparam int unsigned URG_DELAY_DEF  = 64;
  localparam int unsigned MAX_OWED_DEF   = 3;

  function automatic int unsigned owed_width(input int unsigned max_owed);
    return $clog2(max_owed + 1);
  endfunction

endpackage

// File: rtl/ram_refresh_sched_timer.sv
// Free-running refresh interval timer; Tick pulses on the last count of each period.
module ref_interval_timer #(
  parameter int unsigned REF_PERIOD = 390
) (
  input  logic CLK,
  input  logic RST,
  input  logic En,
  output logic Tick
);

  localparam int unsigned CW = $clog2(REF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    Tick  = 1'b0;
    if (En) begin
      if (cnt_q == LAST) begin
        Tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_refresh_sched.sv
// DRAM refresh scheduler: tracks owed refreshes, raises RefReq/RefUrg, and
// inserts a one-cycle request gap after each controller acknowledge.
module ram_refresh_sched
  import ram_ref_pkg::*;
#(
  parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
  parameter int unsigned URG_DELAY  = URG_DELAY_DEF,
  parameter int unsigned MAX_OWED   = MAX_OWED_DEF
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             En,
  input  logic                             RefActive,
  output logic                             RefReq,
  output logic                             RefUrg,
  output logic [owed_width(MAX_OWED)-1:0]  Owed,
  output logic                             Overrun
);

  localparam int unsigned OW = owed_width(MAX_OWED);
  localparam int unsigned AW = $clog2(URG_DELAY + 1);
  localparam logic [OW-1:0] OWED_MAX = OW'(MAX_OWED);
  localparam logic [AW-1:0] AGE_MAX  = AW'(URG_DELAY);

  logic          tick;
  logic          ack;
  logic          served;
  logic          ract_q;
  logic [OW-1:0] owed_q, owed_d;
  logic [AW-1:0] age_q, age_d;
  logic          ovr_q, ovr_d;
  logic          req_q, req_d;
  logic          urg_q, urg_d;
  ref_state_e    state_q, state_d;

  ref_interval_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .En   (En),
    .Tick (tick)
  );

  assign ack = RefActive & ~ract_q;

  // A tick coinciding with a serviced ack nets to zero and cannot overrun.
  always_comb begin
    owed_d = owed_q;
    ovr_d  = ovr_q;
    served = 1'b0;
    if (tick && ack && (owed_q != '0)) begin
      served = 1'b1;
    end else if (tick) begin
      if (owed_q == OWED_MAX) ovr_d  = 1'b1;
      else                    owed_d = owed_q + OW'(1);
    end else if (ack && (owed_q != '0)) begin
      owed_d = owed_q - OW'(1);
      served = 1'b1;
    end
  end

  always_comb begin
    age_d = age_q;
    if (served || (owed_q == '0)) age_d = '0;
    else if (age_q != AGE_MAX)    age_d = age_q + AW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (owed_q != '0) state_d = ST_PEND;
      ST_PEND: if (ack)          state_d = ST_GAP;
      ST_GAP:  state_d = (owed_q != '0) ? ST_PEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    req_d = (state_d == ST_PEND);
    urg_d = req_d && ((age_d >= AGE_MAX) || (owed_d >= OW'(2)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ract_q  <= 1'b0;
      owed_q  <= '0;
      age_q   <= '0;
      ovr_q   <= 1'b0;
      req_q   <= 1'b0;
      urg_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      ract_q  <= RefActive;
      owed_q  <= owed_d;
      age_q   <= age_d;
      ovr_q   <= ovr_d;
      req_q   <= req_d;
      urg_q   <= urg_d;
      state_q <= state_d;
    end
  end

  assign RefReq  = req_q;
  assign RefUrg  = urg_q;
  assign Owed    = owed_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_ram_refresh_sched.sv
// Scoreboard bench for ram_refresh_sched with REF_PERIOD=8, URG_DELAY=4, MAX_OWED=3.
module tb_ram_refresh_sched;

  localparam int RP  = 8;
  localparam int UD  = 4;
  localparam int MO  = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       En;
  logic       RefActive;
  logic       RefReq;
  logic       RefUrg;
  logic [1:0] Owed;
  logic       Overrun;

  ram_refresh_sched #(
    .REF_PERIOD(RP),
    .URG_DELAY (UD),
    .MAX_OWED  (MO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .En        (En),
    .RefActive (RefActive),
    .RefReq    (RefReq),
    .RefUrg    (RefUrg),
    .Owed      (Owed),
    .Overrun   (Overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       req;
    logic       urg;
    logic [1:0] owed;
    logic       ovr;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // reference model state: st 0=idle 1=pending 2=gap
  int m_cnt, m_owed, m_age, m_st, m_ovr, m_ract;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_owed = 0; m_age = 0; m_st = 0; m_ovr = 0; m_ract = 0;
    sbq.delete();
  endtask

  task automatic step(input logic ract, input logic en);
    int   tick, ack, net, n_owed, n_age, n_st, n_ovr;
    exp_t e;
    RefActive = ract;
    En        = en;
    tick   = (en && m_cnt == RP - 1) ? 1 : 0;
    ack    = (ract && !m_ract) ? 1 : 0;
    n_owed = m_owed;
    n_ovr  = m_ovr;
    net    = 0;
    if (tick && ack && m_owed > 0) net = 1;
    else if (tick) begin
      if (m_owed == MO) n_ovr = 1;
      else n_owed = m_owed + 1;
    end else if (ack && m_owed > 0) begin
      n_owed = m_owed - 1;
      net = 1;
    end
    if (net || m_owed == 0) n_age = 0;
    else n_age = (m_age + 1 > UD) ? UD : m_age + 1;
    case (m_st)
      0:       n_st = (m_owed > 0) ? 1 : 0;
      1:       n_st = ack ? 2 : 1;
      default: n_st = (m_owed > 0) ? 1 : 0;
    endcase
    e.req  = (n_st == 1);
    e.urg  = (n_st == 1) && (n_age >= UD || n_owed >= 2);
    e.owed = 2'(n_owed);
    e.ovr  = n_ovr[0];
    sbq.push_back(e);
    m_cnt  = en ? (tick ? 0 : m_cnt + 1) : m_cnt;
    m_owed = n_owed; m_age = n_age; m_st = n_st; m_ovr = n_ovr; m_ract = ract;
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      check_eq("sb_req",  RefReq,  e.req);
      check_eq("sb_urg",  RefUrg,  e.urg);
      check_eq("sb_owed", Owed,    e.owed);
      check_eq("sb_ovr",  Overrun, e.ovr);
    end
  endtask

  task automatic run(input int n, input logic ract, input logic en);
    for (int i = 0; i < n; i++) step(ract, en);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"},  RefReq,  0);
    check_eq({tag, "_urg"},  RefUrg,  0);
    check_eq({tag, "_owed"}, Owed,    0);
    check_eq({tag, "_ovr"},  Overrun, 0);
  endtask

  initial begin
    RST = 1'b1; En = 1'b1; RefActive = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("rst");
    RST = 1'b0;

    // first tick, request, then urgency by age
    run(7, 1'b0, 1'b1);
    check_eq("t1_owed_pre", Owed, 0);
    step(1'b0, 1'b1);
    check_eq("t1_owed", Owed, 1);
    check_eq("t1_req_pre", RefReq, 0);
    step(1'b0, 1'b1);
    check_eq("t1_req", RefReq, 1);
    run(2, 1'b0, 1'b1);
    check_eq("t1_urg_pre", RefUrg, 0);
    step(1'b0, 1'b1);
    check_eq("t1_urg", RefUrg, 1);

    // long RefActive level services exactly once
    step(1'b1, 1'b1);
    check_eq("t2_owed", Owed, 0);
    check_eq("t2_gap_req", RefReq, 0);
    check_eq("t2_gap_urg", RefUrg, 0);
    step(1'b1, 1'b1);
    check_eq("t2_idle_req", RefReq, 0);
    step(1'b1, 1'b1);
    check_eq("t2_single", Owed, 0);
    step(1'b1, 1'b1);
    check_eq("t2_next_tick", Owed, 1);

    // backlog to saturation and overrun
    run(24, 1'b0, 1'b1);
    check_eq("t3_owed", Owed, 3);
    check_eq("t3_ovr", Overrun, 1);
    check_eq("t3_urg", RefUrg, 1);

    // gap re-arm
    step(1'b1, 1'b1);
    check_eq("t4a_owed", Owed, 2);
    check_eq("t4a_gap", RefReq, 0);
    step(1'b0, 1'b1);
    check_eq("t4a_rereq", RefReq, 1);
    check_eq("t4a_urg", RefUrg, 1);
    step(1'b1, 1'b1);
    check_eq("t4b_owed", Owed, 1);
    check_eq("t4b_gap_req", RefReq, 0);
    check_eq("t4b_gap_urg", RefUrg, 0);
    step(1'b0, 1'b1);
    check_eq("t4b_rereq", RefReq, 1);
    run(4, 1'b0, 1'b1);
    check_eq("t6_pre_owed", Owed, 2);

    // asynchronous reset between clock edges
    #3;
    RST = 1'b1;
    #1;
    check_all_zero("arst");
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    run(7, 1'b0, 1'b1);
    check_eq("t6_owed_pre", Owed, 0);
    step(1'b0, 1'b1);
    check_eq("t6_tick", Owed, 1);

    // tick and ack in the same cycle
    run(7, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_eq("t5a_owed", Owed, 1);
    check_eq("t5a_ovr", Overrun, 0);
    check_eq("t5a_gap", RefReq, 0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_eq("t5b_owed_pre", Owed, 0);
    run(5, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_eq("t5b_owed", Owed, 1);
    check_eq("t5b_ovr", Overrun, 0);
    check_eq("t5b_req", RefReq, 0);
    step(1'b0, 1'b1);
    check_eq("t5b_rereq", RefReq, 1);

    // En low freezes the timer but pending work is still serviced
    run(5, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("en_serviced", Owed, 0);
    run(10, 1'b0, 1'b0);
    check_eq("en_frozen", Owed, 0);
    run(6, 1'b0, 1'b1);
    check_eq("en_resume_pre", Owed, 0);
    step(1'b0, 1'b1);
    check_eq("en_resume", Owed, 1);

    // mixed random traffic against the model
    for (int i = 0; i < 120; i++) begin
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
    end

    check_eq("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
